// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared types and constants for the IF/LS memory arbiter.
//               FSM state encoding, owner encoding and the default watchdog
//               limit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Transaction owner; also used as the round-robin priority holder.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Default watchdog limit in cycles spent in REQ+RESP.
    localparam int c_DEFAULT_TIMEOUT = 255;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_arbiter_if
// Description : Bundles the instruction-fetch, load/store and memory-side
//               handshake signals around the memory arbiter.
//   master : arbiter view - accepts IF/LS requests, returns their responses
//            and masters the single memory port.
//   slave  : environment view - IF/LS requesters and the memory device.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = 8
);
    // Instruction fetch channel
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_rdata;

    // Load/store channel
    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic                  ls_wen;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic [MASK_WIDTH-1:0] ls_wmask;
    logic                  ls_resp_valid;
    logic [DATA_WIDTH-1:0] ls_rdata;

    // Memory port
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_rdata,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Grant is combinational on the
//               request vector; the priority flop moves to the non-granted
//               requester whenever update is asserted with a live grant.
// Ports       : clk    - clock
//               rst    - asynchronous active-high reset (priority -> IF)
//               req    - request vector, bit0 = IF, bit1 = LS
//               update - commit the current grant and rotate priority
//               gnt    - one-hot grant (or 0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    input  wire logic       update,
    output logic      [1:0] gnt
);

    owner_e r_prio;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_prio == OWN_LS) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= OWN_IF;
        end else if (update && (gnt != 2'b00)) begin
            // Winner loses priority for the next contested round.
            r_prio <= gnt[0] ? OWN_LS : OWN_IF;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between instruction fetch (IF) and
//               load/store (LS). Round-robin grant in IDLE, latched request
//               driven in REQ, response routed to the owner in RESP. One
//               transaction outstanding; a watchdog aborts hung transactions
//               and raises a sticky error.
// Ports       : clk         - clock
//               rst         - asynchronous active-high reset
//               bus         - mem_arbiter_if.master (IF, LS and memory sides)
//               timeout_err - sticky watchdog flag, cleared only by rst
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int MASK_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.master bus,
    output logic          timeout_err
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    arb_state_e            r_state;
    arb_state_e            w_nextState;
    owner_e                r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [MASK_WIDTH-1:0] r_wmask;
    logic [CNT_W-1:0]      r_wdogCnt;
    logic                  r_timeoutErr;

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_grant;
    logic                  w_done;
    logic                  w_timeout;

    // Requests are masked while reset is held so no ready is shown then.
    assign w_req = rst ? 2'b00 : {bus.ls_req_valid, bus.if_req_valid};

    rr_arb2 u_rrArb (
        .clk    (clk),
        .rst    (rst),
        .req    (w_req),
        .update (w_grant),
        .gnt    (w_gnt)
    );

    assign w_grant   = (r_state == IDLE) && (w_gnt != 2'b00);
    assign w_done    = (r_state == RESP) && bus.mem_resp_valid;
    // A response arriving in the limit cycle still completes normally.
    assign w_timeout = (r_state != IDLE) && (r_wdogCnt == c_TIMEOUT) && !w_done;

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState       = r_state;
        bus.if_req_ready  = 1'b0;
        bus.ls_req_ready  = 1'b0;
        bus.if_resp_valid = 1'b0;
        bus.if_rdata      = '0;
        bus.ls_resp_valid = 1'b0;
        bus.ls_rdata      = '0;
        bus.mem_req_valid = 1'b0;

        case (r_state)
            IDLE: begin
                bus.if_req_ready = w_gnt[0];
                bus.ls_req_ready = w_gnt[1];
                if (w_grant) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                // Dropped in the abort cycle so memory cannot accept it.
                bus.mem_req_valid = !w_timeout;
                if (w_timeout) begin
                    w_nextState = IDLE;
                end else if (bus.mem_req_ready) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (w_done || w_timeout) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        // Completion forwards memory data; an abort returns zero data.
        if (w_done || w_timeout) begin
            if (r_owner == OWN_IF) begin
                bus.if_resp_valid = 1'b1;
                bus.if_rdata      = w_done ? bus.mem_rdata : '0;
            end else begin
                bus.ls_resp_valid = 1'b1;
                bus.ls_rdata      = w_done ? bus.mem_rdata : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, latched request, watchdog and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_wdogCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_grant) begin
                r_wdogCnt <= '0;
                if (w_gnt[1]) begin
                    r_owner <= OWN_LS;
                    r_addr  <= bus.ls_addr;
                    r_wen   <= bus.ls_wen;
                    r_wdata <= bus.ls_wdata;
                    r_wmask <= bus.ls_wmask;
                end else begin
                    // Fetches are always reads.
                    r_owner <= OWN_IF;
                    r_addr  <= bus.if_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            end else if ((r_state != IDLE) && (r_wdogCnt != c_TIMEOUT)) begin
                // Saturates at the limit, so it can never wrap.
                r_wdogCnt <= r_wdogCnt + c_ONE;
            end

            if (w_timeout) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wen   = r_wen;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wmask = r_wmask;
    assign timeout_err   = r_timeoutErr;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Expected responses are
//               queued when a grant is expected and matched by a monitor on
//               every response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = 8;

    typedef struct {
        logic [1:0]  owner;   // bit0 = IF, bit1 = LS
        logic [63:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic timeoutErr;

    int   nChecks;
    int   nErrors;
    exp_t sbq[$];

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MASK_WIDTH     (MW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .timeout_err (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
        end
    endtask

    // Response monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (bus.if_resp_valid || bus.ls_resp_valid)) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_owner", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, {62'd0, e.owner});
                if (e.owner == 2'b01) begin
                    check("sb_if_rdata", bus.if_rdata, e.data);
                    check("sb_ls_rdata_idle", bus.ls_rdata, 64'd0);
                end else begin
                    check("sb_ls_rdata", bus.ls_rdata, e.data);
                    check("sb_if_rdata_idle", bus.if_rdata, 64'd0);
                end
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle with requests driven.
    task automatic grant(input logic [1:0] expGnt, input logic [63:0] data);
        exp_t e;
        @(negedge clk);
        check("grant", {62'd0, bus.ls_req_ready, bus.if_req_ready}, {62'd0, expGnt});
        e.owner = expGnt;
        e.data  = data;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 of the first REQ cycle; acts as the memory.
    task automatic serveMem(input logic [1:0] owner, input logic [63:0] addr,
                            input logic wen, input logic [63:0] wdata,
                            input logic [7:0] wmask, input int readyDelay,
                            input bit stray, input logic [63:0] data);
        for (int i = 0; i < readyDelay; i++) begin
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = stray;
            bus.mem_rdata      = stray ? 64'hBAD0_BAD0 : 64'd0;
            @(negedge clk);
            check("bp_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
            check("bp_addr", bus.mem_addr, addr);
            check("bp_no_ready", {62'd0, bus.ls_req_ready, bus.if_req_ready}, 64'd0);
            check("bp_no_resp", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd0);
            @(posedge clk); #1;
        end
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 64'd0;
        @(negedge clk);
        check("req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
        check("mem_addr", bus.mem_addr, addr);
        check("mem_wen", {63'd0, bus.mem_wen}, {63'd0, wen});
        check("mem_wmask", {56'd0, bus.mem_wmask}, {56'd0, wmask});
        if (wen) check("mem_wdata", bus.mem_wdata, wdata);
        @(posedge clk); #1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = data;
        @(negedge clk);
        check("resp_req_low", {63'd0, bus.mem_req_valid}, 64'd0);
        check("resp_owner", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, {62'd0, owner});
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 64'd0;
    endtask

    initial begin : stim
        nChecks = 0;
        nErrors = 0;
        rst = 1'b1;
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = '0;
        bus.ls_req_valid   = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_wen         = 1'b0;
        bus.ls_wdata       = '0;
        bus.ls_wmask       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;

        // ---------------- Reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        @(negedge clk);
        check("rst_ready", {62'd0, bus.ls_req_ready, bus.if_req_ready}, 64'd0);
        check("rst_mreq", {63'd0, bus.mem_req_valid}, 64'd0);
        check("rst_maddr", bus.mem_addr, 64'd0);
        check("rst_err", {63'd0, timeoutErr}, 64'd0);
        @(posedge clk); #1;
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        rst = 1'b0;

        // ---------------- Stray response in IDLE ----------------
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h1234;
        repeat (2) begin
            @(negedge clk);
            check("stray_resp", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd0);
            check("stray_mreq", {63'd0, bus.mem_req_valid}, 64'd0);
            @(posedge clk); #1;
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 64'd0;

        // ---------------- Contested requests alternate ----------------
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0004;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_9000;
        bus.ls_wen       = 1'b1;
        bus.ls_wdata     = 64'hDEAD_BEEF;
        bus.ls_wmask     = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 0) begin
                grant(2'b01, 64'h0000_0013 + 64'(k));
                if (k == 3) begin bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0; end
                serveMem(2'b01, 64'h8000_0004, 1'b0, 64'd0, 8'h00, 0, 1'b0, 64'h0000_0013 + 64'(k));
            end else begin
                grant(2'b10, 64'hA5A5_0000 + 64'(k));
                if (k == 3) begin bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0; end
                serveMem(2'b10, 64'h8000_9000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 0, 1'b0, 64'hA5A5_0000 + 64'(k));
            end
        end
        bus.ls_wen   = 1'b0;
        bus.ls_wmask = 8'h00;

        // ---------------- Single IF read; inputs changed after grant ----------------
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0000;
        grant(2'b01, 64'h0010_0093);
        bus.if_req_valid = 1'b0;
        bus.if_addr      = 64'hFFFF_0000;
        serveMem(2'b01, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 0, 1'b0, 64'h0010_0093);

        // ---------------- Backpressure with stray response in REQ ----------------
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_1000;
        grant(2'b10, 64'h1122_3344_5566_7788);
        bus.ls_req_valid = 1'b0;
        bus.ls_addr      = 64'h0;
        serveMem(2'b10, 64'h8000_1000, 1'b0, 64'd0, 8'h00, 5, 1'b1, 64'h1122_3344_5566_7788);

        // ---------------- Watchdog timeout on an LS load ----------------
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_2000;
        grant(2'b10, 64'd0);
        bus.ls_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("to_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            check("to_wait_resp", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd0);
            check("to_wait_err", {63'd0, timeoutErr}, 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_pulse", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_err_set", {63'd0, timeoutErr}, 64'd1);
        check("to_no_repeat", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd0);

        // Normal IF after timeout; error stays set.
        @(posedge clk); #1;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0008;
        grant(2'b01, 64'h0000_0513);
        bus.if_req_valid = 1'b0;
        serveMem(2'b01, 64'h8000_0008, 1'b0, 64'd0, 8'h00, 0, 1'b0, 64'h0000_0513);
        @(negedge clk);
        check("to_err_sticky", {63'd0, timeoutErr}, 64'd1);
        @(posedge clk); #1;

        // ---------------- Async reset mid-RESP ----------------
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0010;
        grant(2'b01, 64'd0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("ar_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        bus.ls_req_valid  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("ar_mreq", {63'd0, bus.mem_req_valid}, 64'd0);
        check("ar_err", {63'd0, timeoutErr}, 64'd0);
        check("ar_maddr", bus.mem_addr, 64'd0);
        check("ar_ready", {62'd0, bus.ls_req_ready, bus.if_req_ready}, 64'd0);
        check("ar_resp", {62'd0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        grant(2'b01, 64'h0000_0777);
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        serveMem(2'b01, 64'h8000_0010, 1'b0, 64'd0, 8'h00, 0, 1'b0, 64'h0000_0777);

        @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
